// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between the non-stallable WB stage and a 1-entry MDU holding register.
// Optional RFWA_WAW_SQUASH_EN: a WB write to the held destination invalidates the held entry.
module regfile_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0] rf_busw,
    output logic              hold_valid,
    output logic [ADDR_W-1:0] hold_rd,
    output logic              stall_req
);

    typedef enum logic [1:0] {IDLE, HOLD, STARVE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] STARVE_AT = CNT_W'(STARVE_LIMIT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] hold_rd_q;
    logic [DATA_W-1:0] hold_data;
    logic              stall_q;
    logic              wb_wr, hold_grant, accept, squash;

    assign wb_wr      = wb_valid && (wb_rd != '0);
    assign hold_valid = (state != IDLE);
    assign mdu_ready  = !hold_valid;
    assign hold_rd    = hold_rd_q;
    assign stall_req  = stall_q;
    assign hold_grant = hold_valid && !wb_wr;
    // Results aimed at r0 are consumed here and never occupy the hold register.
    assign accept     = mdu_valid && mdu_ready && (mdu_rd != '0);

`ifdef RFWA_WAW_SQUASH_EN
    // The younger WB value supersedes the pending MDU result for the same register.
    assign squash = wb_wr && hold_valid && (wb_rd == hold_rd_q);
`else
    assign squash = 1'b0;
`endif

    always_comb begin
        rf_we   = 1'b0;
        rf_rw   = '0;
        rf_busw = '0;
        if (wb_wr) begin
            rf_we   = 1'b1;
            rf_rw   = wb_rd;
            rf_busw = wb_data;
        end else if (hold_valid) begin
            rf_we   = 1'b1;
            rf_rw   = hold_rd_q;
            rf_busw = hold_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = HOLD;
                    wait_cnt_nxt = '0;
                end
            end
            HOLD, STARVE: begin
                if (hold_grant || squash) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    if (wait_cnt != CNT_MAX)
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    // Compare the pre-increment count so STARVE_LIMIT denied cycles elapse first.
                    if (state == HOLD && wait_cnt == STARVE_AT)
                        state_nxt = STARVE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hold_rd_q <= '0;
            hold_data <= '0;
            stall_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            stall_q  <= (state_nxt == STARVE);
            if (accept) begin
                hold_rd_q <= mdu_rd;
                hold_data <= mdu_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed table, hand sequences for starvation/WAW/reset, random vs queue-level model.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;
    localparam int CW = 3;

    logic          clk, reset;
    logic          wb_valid, mdu_valid;
    logic [AW-1:0] wb_rd, mdu_rd;
    logic [DW-1:0] wb_data, mdu_data;
    logic          mdu_ready, rf_we, hold_valid, stall_req;
    logic [AW-1:0] rf_rw, hold_rd;
    logic [DW-1:0] rf_busw;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_rw(rf_rw), .rf_busw(rf_busw),
        .hold_valid(hold_valid), .hold_rd(hold_rd), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a pending slot plus a count of cycles it has been refused the port.
    logic          m_pend;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    int            m_denied;

    typedef struct {
        logic          wbv;
        logic [AW-1:0] wbrd;
        logic [DW-1:0] wbd;
        logic          mv;
        logic [AW-1:0] mrd;
        logic [DW-1:0] md;
        logic          we;
        logic [AW-1:0] rw;
        logic [DW-1:0] busw;
        logic          rdy;
        logic          hv;
        logic          stall;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pend = 1'b0; m_rd = '0; m_data = '0; m_denied = 0;
    endtask

    // Drive one cycle's inputs (from a negedge) and compare every output to the model.
    task automatic apply(input logic wbv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
        logic          wbw;
        logic [AW-1:0] e_rw;
        logic [DW-1:0] e_bus;
        wb_valid = wbv; wb_rd = wrd; wb_data = wd;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
        #1;
        wbw   = wbv && (wrd != '0);
        e_rw  = wbw ? wrd : (m_pend ? m_rd : '0);
        e_bus = wbw ? wd : (m_pend ? m_data : '0);
        chk("m_we",    DW'(rf_we),      DW'(wbw || m_pend));
        chk("m_rw",    DW'(rf_rw),      DW'(e_rw));
        chk("m_busw",  rf_busw,         e_bus);
        chk("m_ready", DW'(mdu_ready),  DW'(!m_pend));
        chk("m_hv",    DW'(hold_valid), DW'(m_pend));
        chk("m_stall", DW'(stall_req),  DW'(m_pend && m_denied >= SL));
        if (m_pend) chk("m_hrd", DW'(hold_rd), DW'(m_rd));
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        logic wbw;
        @(posedge clk);
        wbw = wb_valid && (wb_rd != '0);
        if (m_pend) begin
            if (!wbw) begin
                m_pend = 1'b0; m_denied = 0;
`ifdef RFWA_WAW_SQUASH_EN
            end else if (wb_rd == m_rd) begin
                m_pend = 1'b0; m_denied = 0;
`endif
            end else begin
                m_denied++;
            end
        end else if (mdu_valid && mdu_rd != '0) begin
            m_pend = 1'b1; m_rd = mdu_rd; m_data = mdu_data; m_denied = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hCAFE, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        m_reset();
        #1;
        chk("rst_hv",    DW'(hold_valid), DW'(1'b0));
        chk("rst_stall", DW'(stall_req),  DW'(1'b0));
        chk("rst_ready", DW'(mdu_ready),  DW'(1'b1));
        chk("rst_we",    DW'(rf_we),      DW'(1'b0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Basic WB write, MDU accept/write, r0 handling.
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            chk($sformatf("tbl%0d_we", i),    DW'(rf_we),      DW'(tbl[i].we));
            chk($sformatf("tbl%0d_rw", i),    DW'(rf_rw),      DW'(tbl[i].rw));
            chk($sformatf("tbl%0d_busw", i),  rf_busw,         tbl[i].busw);
            chk($sformatf("tbl%0d_ready", i), DW'(mdu_ready),  DW'(tbl[i].rdy));
            chk($sformatf("tbl%0d_hv", i),    DW'(hold_valid), DW'(tbl[i].hv));
            chk($sformatf("tbl%0d_stall", i), DW'(stall_req),  DW'(tbl[i].stall));
            tick();
        end

        // Starvation: six busy WB cycles, stall from the fifth, cleared one cycle after the grant.
        apply(1'b0, '0, '0, 1'b1, 5'd9, 32'hBEEF); tick();
        for (int i = 1; i <= 6; i++) begin
            apply(1'b1, 5'd3, DW'(i), 1'b0, '0, '0);
            chk($sformatf("starve_c%0d", i), DW'(stall_req), DW'(i >= 5));
            tick();
        end
        idle();
        chk("starve_grant_rw",    DW'(rf_rw),     DW'(5'd9));
        chk("starve_grant_busw",  rf_busw,        32'hBEEF);
        chk("starve_grant_stall", DW'(stall_req), DW'(1'b1));
        tick();
        idle();
        chk("starve_clear", DW'(stall_req), DW'(1'b0));
        tick();

        // WAW on the held destination.
        apply(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777); tick();
        apply(1'b1, 5'd7, 32'h1111, 1'b0, '0, '0);
        chk("waw_wb_busw", rf_busw, 32'h1111);
        tick();
        idle();
`ifdef RFWA_WAW_SQUASH_EN
        chk("waw_sq_we", DW'(rf_we),      DW'(1'b0));
        chk("waw_sq_hv", DW'(hold_valid), DW'(1'b0));
`else
        chk("waw_we",   DW'(rf_we), DW'(1'b1));
        chk("waw_rw",   DW'(rf_rw), DW'(5'd7));
        chk("waw_busw", rf_busw,    32'h7777);
`endif
        tick();

        // Reset in STARVE drops the pending result at once.
        apply(1'b0, '0, '0, 1'b1, 5'd12, 32'hDEAD); tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 5'd2, 32'h2, 1'b0, '0, '0); tick();
        end
        apply(1'b1, 5'd2, 32'h2, 1'b0, '0, '0);
        chk("pre_rst_stall", DW'(stall_req), DW'(1'b1));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hv",    DW'(hold_valid), DW'(1'b0));
        chk("mid_rst_stall", DW'(stall_req),  DW'(1'b0));
        chk("mid_rst_ready", DW'(mdu_ready),  DW'(1'b1));
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        chk("post_rst_we", DW'(rf_we), DW'(1'b0));
        tick();

        // Random traffic against the model; narrow rd range provokes r0 and WAW collisions.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
